// File: rtl/rr_priority_encoder_pkg.sv
// Shared types for the round-robin / fixed-priority request encoder.
//   mode_e : arbitration mode carried on the request interface.
package prio_enc_pkg;

  // Arbitration mode: fixed lowest-index-wins, or rotating round-robin.
  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

endpackage : prio_enc_pkg

// File: rtl/rr_priority_encoder_if.sv
// Request/result bundle between request sources, the encoder and its consumer.
//   en        : capture enable (source side)
//   mode      : arbitration mode (source side)
//   req       : N-bit level request vector (source side)
//   out_ready : consumer accepts the held result (consumer side)
//   out_valid : held result is valid (encoder side)
//   idx       : granted request index (encoder side)
//   multi     : more than one request was set at capture (encoder side)
interface rr_priority_encoder_if
  import prio_enc_pkg::*;
#(
  parameter int unsigned N = 8
) ();

  localparam int unsigned W = $clog2(N);

  logic           en;
  mode_e          mode;
  logic [N-1:0]   req;
  logic           out_ready;
  logic           out_valid;
  logic [W-1:0]   idx;
  logic           multi;

  // Encoder side: consumes requests, produces the registered result.
  modport slave (
    input  en,
    input  mode,
    input  req,
    input  out_ready,
    output out_valid,
    output idx,
    output multi
  );

  // Environment side: drives requests and the consumer ready.
  modport master (
    output en,
    output mode,
    output req,
    output out_ready,
    input  out_valid,
    input  idx,
    input  multi
  );

endinterface : rr_priority_encoder_if

// File: rtl/rr_priority_encoder_ffs_from.sv
// Find-first-set with a start index and wrap-around (purely combinational).
//   v     : N-bit input vector
//   s     : start index; the search covers s, s+1, ..., N-1, 0, ..., s-1
//   found : at least one bit of v is set
//   pos   : index of the first set bit met in that order
module ffs_from #(
  parameter int unsigned N = 8,
  parameter int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] v,
  input  logic [W-1:0] s,
  output logic         found,
  output logic [W-1:0] pos
);

  int unsigned base_c;
  int unsigned cand_c;

  // Walk the N positions in search order and keep the first hit.
  // An out-of-range start (possible only when N is not a power of two)
  // is treated as 0 so the search is always well defined.
  always_comb begin
    found  = 1'b0;
    pos    = '0;
    base_c = (32'(s) < N) ? 32'(s) : 32'd0;
    cand_c = 32'd0;
    for (int unsigned i = 0; i < N; i++) begin
      cand_c = base_c + i;
      if (cand_c >= N) begin
        cand_c = cand_c - N;
      end
      if (!found && v[W'(cand_c)]) begin
        found = 1'b1;
        pos   = W'(cand_c);
      end
    end
  end

endmodule : ffs_from

// File: rtl/rr_priority_encoder.sv
// Registered N-to-log2(N) request encoder with fixed-priority or round-robin
// selection and a valid/ready result handshake.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : rr_priority_encoder_if.slave
//         en/mode/req in, out_ready in; out_valid/idx/multi out (all flopped)
module rr_priority_encoder
  import prio_enc_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  rr_priority_encoder_if.slave  bus
);

  localparam int unsigned W    = $clog2(N);
  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] ptr_q,       ptr_d;
  logic [W-1:0] idx_q,       idx_d;
  logic         multi_q,     multi_d;
  logic         out_valid_q, out_valid_d;

  logic         rr_found_c,  fix_found_c, sel_found_c;
  logic [W-1:0] rr_pos_c,    fix_pos_c,   sel_pos_c;
  logic         slot_free_c;
  logic         capture_c;
  logic         multi_c;
  logic         rr_mode_c;

  // Round-robin search starts at the rotating pointer.
  ffs_from #(
    .N (N),
    .W (W)
  ) u_ffs_rr (
    .v     (bus.req),
    .s     (ptr_q),
    .found (rr_found_c),
    .pos   (rr_pos_c)
  );

  // Fixed priority is the same search anchored at index 0.
  ffs_from #(
    .N (N),
    .W (W)
  ) u_ffs_fix (
    .v     (bus.req),
    .s     ('0),
    .found (fix_found_c),
    .pos   (fix_pos_c)
  );

  assign rr_mode_c   = (bus.mode == MODE_RR);
  assign sel_found_c = rr_mode_c ? rr_found_c : fix_found_c;
  assign sel_pos_c   = rr_mode_c ? rr_pos_c   : fix_pos_c;

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_c     = |(bus.req & (bus.req - N'(1)));

  // The output slot can take a new result when empty or being drained now.
  assign slot_free_c = !out_valid_q || bus.out_ready;
  assign capture_c   = bus.en && sel_found_c && slot_free_c;

  // Next-state: capture, drain, or hold (stall / idle).
  always_comb begin
    ptr_d       = ptr_q;
    idx_d       = idx_q;
    multi_d     = multi_q;
    out_valid_d = out_valid_q;
    if (capture_c) begin
      idx_d       = sel_pos_c;
      multi_d     = multi_c;
      out_valid_d = 1'b1;
      if (rr_mode_c) begin
        // Explicit wrap keeps ptr inside 0..N-1 for non-power-of-two N.
        ptr_d = (sel_pos_c == LAST) ? '0 : sel_pos_c + W'(1);
      end
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= '0;
      idx_q       <= '0;
      multi_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      idx_q       <= idx_d;
      multi_q     <= multi_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.idx       = idx_q;
  assign bus.multi     = multi_q;

endmodule : rr_priority_encoder

// File: tb/tb_rr_priority_encoder.sv
// Scoreboard bench for rr_priority_encoder: an N=8 and an N=5 instance.
module tb_rr_priority_encoder;
  import prio_enc_pkg::*;

  typedef struct packed {
    logic [2:0] idx;
    logic       multi;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  rr_priority_encoder_if #(.N(8)) a_if ();
  rr_priority_encoder_if #(.N(5)) b_if ();

  rr_priority_encoder #(.N(8)) dut_a (.clk(clk), .rst(rst), .bus(a_if));
  rr_priority_encoder #(.N(5)) dut_b (.clk(clk), .rst(rst), .bus(b_if));

  always #5 clk = ~clk;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea;
  exp_t eb;
  int   total = 0;
  int   bad   = 0;

  int rr_idx [5] = '{0, 2, 7, 0, 2};
  int rr_ptr [5] = '{1, 3, 0, 1, 3};
  int b_idx  [3] = '{0, 4, 0};
  int b_ptr  [3] = '{1, 0, 1};

  function automatic exp_t mk(input int i, input logic m);
    exp_t e;
    e.idx   = 3'(i);
    e.multi = m;
    return e;
  endfunction

  task automatic check(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitors: every accepted result is popped and compared in order.
  always @(negedge clk) begin
    if (!rst && a_if.out_valid && a_if.out_ready) begin
      if (qa.size() == 0) begin
        total++;
        bad++;
        $display("FAIL a_unexpected: got idx=%0d with empty queue", a_if.idx);
      end else begin
        ea = qa.pop_front();
        check("a_idx",   int'(a_if.idx),   int'(ea.idx));
        check("a_multi", int'(a_if.multi), int'(ea.multi));
      end
    end
    if (!rst && b_if.out_valid && b_if.out_ready) begin
      if (qb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL b_unexpected: got idx=%0d with empty queue", b_if.idx);
      end else begin
        eb = qb.pop_front();
        check("b_idx",   int'(b_if.idx),   int'(eb.idx));
        check("b_multi", int'(b_if.multi), int'(eb.multi));
      end
    end
  end

  initial begin
    a_if.en = 1'b0; a_if.mode = MODE_FIXED; a_if.req = '0; a_if.out_ready = 1'b0;
    b_if.en = 1'b0; b_if.mode = MODE_FIXED; b_if.req = '0; b_if.out_ready = 1'b0;

    // Power-on reset.
    #1 rst = 1'b1;
    #2;
    check("rst_valid", int'(a_if.out_valid), 0);
    check("rst_idx",   int'(a_if.idx),       0);
    check("rst_ptr",   int'(dut_a.ptr_q),    0);
    @(negedge clk) rst = 1'b0;
    step();

    // en low blocks capture even with requests present.
    a_if.en = 1'b0; a_if.req = 8'hFF; a_if.out_ready = 1'b1;
    repeat (3) begin step(); check("en_low_valid", int'(a_if.out_valid), 0); end

    // req zero: no capture.
    a_if.en = 1'b1; a_if.req = 8'h00;
    repeat (3) begin step(); check("req0_valid", int'(a_if.out_valid), 0); end

    // One-hot sweep, fixed mode.
    for (int i = 0; i < 8; i++) begin
      a_if.req = 8'(1 << i);
      qa.push_back(mk(i, 1'b0));
      step();
      check("sweep_valid", int'(a_if.out_valid), 1);
    end

    // Fixed priority with multi-hot request.
    a_if.req = 8'hA4;
    repeat (3) begin
      qa.push_back(mk(2, 1'b1));
      step();
      check("fix_valid", int'(a_if.out_valid), 1);
    end
    check("fix_ptr_unchanged", int'(dut_a.ptr_q), 0);

    // Round-robin rotation with wrap from 7 to 0.
    a_if.mode = MODE_RR; a_if.req = 8'h85;
    for (int i = 0; i < 5; i++) begin
      qa.push_back(mk(rr_idx[i], 1'b1));
      step();
      check("rr_ptr", int'(dut_a.ptr_q), rr_ptr[i]);
    end
    a_if.req = 8'h00;
    step();
    check("drain_valid", int'(a_if.out_valid), 0);

    // Stall: result 2 held while req changes underneath.
    a_if.mode = MODE_FIXED; a_if.req = 8'h04; a_if.out_ready = 1'b0;
    qa.push_back(mk(2, 1'b0));
    step();
    a_if.req = 8'h10;
    repeat (3) begin
      step();
      check("stall_idx",   int'(a_if.idx),       2);
      check("stall_valid", int'(a_if.out_valid), 1);
    end
    check("ptr_kept_across_mode", int'(dut_a.ptr_q), 3);
    a_if.out_ready = 1'b1;
    qa.push_back(mk(4, 1'b0));
    step();
    a_if.out_ready = 1'b0;
    check("release_idx",   int'(a_if.idx),       4);
    check("release_valid", int'(a_if.out_valid), 1);
    step();
    check("stall2_idx", int'(a_if.idx), 4);

    // Asynchronous reset in the middle of a stall discards the result.
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", int'(a_if.out_valid), 0);
    check("mid_rst_idx",   int'(a_if.idx),       0);
    check("mid_rst_multi", int'(a_if.multi),     0);
    check("mid_rst_ptr",   int'(dut_a.ptr_q),    0);
    qa.delete();
    a_if.req = 8'h00; a_if.out_ready = 1'b1;
    @(negedge clk) rst = 1'b0;
    repeat (5) begin step(); check("idle_valid", int'(a_if.out_valid), 0); end

    // Non-power-of-two round robin, N=5.
    b_if.en = 1'b1; b_if.mode = MODE_RR; b_if.req = 5'b10001; b_if.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      qb.push_back(mk(b_idx[i], 1'b1));
      step();
      check("b_ptr", int'(dut_b.ptr_q), b_ptr[i]);
      check("b_ptr_range", int'(dut_b.ptr_q <= 3'd4), 1);
    end
    b_if.req = '0;
    step();
    step();
    check("b_drain_valid", int'(b_if.out_valid), 0);

    check("qa_empty", qa.size(), 0);
    check("qb_empty", qb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_rr_priority_encoder
